// File: rtl/fetch_hazard_ctrl.sv
// fetch_hazard_ctrl: Fetch-stage sequencer arbitrating redirects, stalls, post-redirect bubbles and a branch watchdog.
//   In : I_CLOCK, I_RESET, I_BranchStallSignal, I_DepStallSignal, I_GPUStallSignal, I_BranchAddrSelect, I_BranchPC
//   Out: O_PCSel, O_IRSel, O_FE_Valid (combinational); O_RedirectPC, O_State, O_StallCount, O_BranchTimeout (registered)
module fetch_hazard_ctrl #(
    parameter int PC_WIDTH       = 16,
    parameter int BRANCH_BUBBLES = 2,
    parameter int BR_TIMEOUT     = 15,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                 I_CLOCK,
    input  logic                 I_RESET,
    input  logic                 I_BranchStallSignal,
    input  logic                 I_DepStallSignal,
    input  logic                 I_GPUStallSignal,
    input  logic                 I_BranchAddrSelect,
    input  logic [PC_WIDTH-1:0]  I_BranchPC,
    output logic [1:0]           O_PCSel,
    output logic [1:0]           O_IRSel,
    output logic                 O_FE_Valid,
    output logic [PC_WIDTH-1:0]  O_RedirectPC,
    output logic [1:0]           O_State,
    output logic [CNT_WIDTH-1:0] O_StallCount,
    output logic                 O_BranchTimeout
);
    typedef enum logic [1:0] {RUN = 2'd0, BR_WAIT = 2'd1, BUBBLE = 2'd2} state_t;
    state_t     state;
    logic [2:0] bub_cnt;
    logic [7:0] wd;
    logic       stall;
    logic       fetch;
    logic [7:0] wd_inc;
    logic       wd_fire;
    assign stall   = I_GPUStallSignal | I_DepStallSignal;
    assign fetch   = state == RUN && !I_BranchStallSignal;
    assign wd_inc  = wd + 8'd1;
    // The watchdog fires on the edge that completes the BR_TIMEOUT-th wait cycle; a redirect beats it.
    assign wd_fire = state == BR_WAIT && !I_BranchAddrSelect && wd_inc == 8'(BR_TIMEOUT);
    assign O_State = state;
    always_comb begin
        O_PCSel    = I_RESET ? 2'd0 : I_BranchAddrSelect ? 2'd2 : stall ? 2'd1 : fetch ? 2'd0 : 2'd1;
        O_IRSel    = I_RESET ? 2'd0 : I_BranchAddrSelect ? 2'd2 : stall ? 2'd1 : fetch ? 2'd0 : 2'd2;
        O_FE_Valid = !I_RESET && !I_BranchAddrSelect && (stall || fetch);
    end
    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            state           <= RUN;
            bub_cnt         <= '0;
            wd              <= '0;
            O_RedirectPC    <= '0;
            O_StallCount    <= '0;
            O_BranchTimeout <= 1'b0;
        end else begin
            if (O_PCSel != 2'd0 && O_StallCount != '1)
                O_StallCount <= O_StallCount + 1'b1;
            if (I_BranchAddrSelect) begin
                O_RedirectPC <= I_BranchPC;
                wd           <= '0;
                bub_cnt      <= 3'(BRANCH_BUBBLES);
                state        <= BRANCH_BUBBLES > 0 ? BUBBLE : RUN;
            end else begin
                // The watchdog keeps running while a stall freezes the rest of the sequencer.
                if (state == BR_WAIT)
                    wd <= wd_fire ? 8'd0 : wd_inc;
                if (wd_fire) begin
                    O_BranchTimeout <= 1'b1;
                    state           <= RUN;
                end else if (!stall) begin
                    if (state == RUN && I_BranchStallSignal) begin
                        state <= BR_WAIT;
                        wd    <= '0;
                    end
                    if (state == BUBBLE) begin
                        bub_cnt <= bub_cnt - 3'd1;
                        if (bub_cnt <= 3'd1)
                            state <= RUN;
                    end
                end
            end
        end
    end
endmodule
